dmem_port_arbiter: RTL and testbench

Two-requester arbiter placed in front of the single-port data memory, sharing it between the core load/store unit (port 0) and the DMA/debug loader (port 1). Each cycle it grants at most one access, drives the memory's read/write strobes, address and write data, and returns registered read data to the winning port one cycle later. Arbitration is least-recently-granted with a bounded burst, so neither port can starve the other.

---
 rtl/dmem_port_arbiter.sv | 82 ++++++++
 tb/tb_dmem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: two-port least-recently-granted arbiter with bounded burst in front of a single-port data memory
module dmem_port_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(BURST_MAX);
  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_e;
  owner_e owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_q, last_d;
  logic rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic any_req, pick1, we_w, same;
  always_comb begin
    any_req = req0 | req1;
    // pick1: port 1 wins; with an idle owner the least-recently-granted port wins contention
    pick1 = req1 & (~req0 | (owner_q == OWN_NONE ? ~last_q :
                             owner_q == OWN_P1 ? cnt_q < CMAX : cnt_q >= CMAX));
    gnt0 = req0 & ~pick1;
    gnt1 = pick1;
    we_w = pick1 ? we1 : we0;
    MemRead = any_req & ~we_w;
    MemWrite = any_req & we_w;
    mem_addr = !any_req ? '0 : pick1 ? addr1 : addr0;
    mem_wdata = !any_req ? '0 : pick1 ? wdata1 : wdata0;
    same = owner_q == (pick1 ? OWN_P1 : OWN_P0);
    owner_d = !any_req ? OWN_NONE : pick1 ? OWN_P1 : OWN_P0;
    cnt_d = !any_req ? '0 : !same ? CW'(1) : cnt_q == CMAX ? cnt_q : cnt_q + 1'b1;
    last_d = any_req ? pick1 : last_q;
    rvalid0_d = MemRead & ~pick1;
    rvalid1_d = MemRead & pick1;
    rdata0_d = rvalid0_d ? mem_rdata : rdata0_q;
    rdata1_d = rvalid1_d ? mem_rdata : rdata1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      cnt_q <= '0;
      last_q <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scenario tasks plus randomized traffic against a grant-history reference model
module tb_dmem_port_arbiter;
  localparam int BM = 4;
  logic clk, rst_n, req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1, MemRead, MemWrite;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] tbmem [64];
  logic [31:0] refmem [64];
  int n_chk = 0, n_fail = 0;
  int hist [$];
  int exp_w;
  logic exp_g0, exp_g1, exp_mr, exp_mw, exp_rv0, exp_rv1;
  logic [31:0] exp_addr, exp_wd, exp_rd0, exp_rd1;

  dmem_port_arbiter #(.BURST_MAX(BM), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign mem_rdata = tbmem[mem_addr[7:2]];
  always @(posedge clk) if (MemWrite) tbmem[mem_addr[7:2]] <= mem_wdata;

  // Winner from the grant history: a lone requester wins; under contention the
  // current streak holder keeps it until BM grants, and after an idle cycle the
  // port not granted most recently wins (port 1 counts as last after reset).
  function automatic int m_winner();
    int prev, s, lg;
    if (!req0 && !req1) return -1;
    if (req0 != req1) return req0 ? 0 : 1;
    prev = hist.size() > 0 ? hist[hist.size()-1] : -1;
    if (prev < 0) begin
      lg = 1;
      for (int i = hist.size() - 1; i >= 0; i--) if (hist[i] >= 0) begin lg = hist[i]; break; end
      return 1 - lg;
    end
    s = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == prev; i--) s++;
    return s < BM ? prev : 1 - prev;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_rv0 = 0; exp_rv1 = 0; exp_rd0 = 0; exp_rd1 = 0;
  endtask

  task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, input logic [31:0] a1, d1);
    logic wew;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    exp_w = m_winner();
    exp_g0 = exp_w == 0;
    exp_g1 = exp_w == 1;
    wew = exp_w == 1 ? w1 : w0;
    exp_mr = exp_w >= 0 && !wew;
    exp_mw = exp_w >= 0 && wew;
    exp_addr = exp_w < 0 ? 32'h0 : exp_w == 1 ? a1 : a0;
    exp_wd = exp_w < 0 ? 32'h0 : exp_w == 1 ? d1 : d0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      hist.push_back(exp_w);
      exp_rv0 = 0; exp_rv1 = 0;
      if (exp_mw) refmem[exp_addr[7:2]] = exp_wd;
      if (exp_mr && exp_w == 0) begin exp_rv0 = 1; exp_rd0 = refmem[exp_addr[7:2]]; end
      if (exp_mr && exp_w == 1) begin exp_rv1 = 1; exp_rd1 = refmem[exp_addr[7:2]]; end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    n_chk++;
    if (gnt0 !== 0 || gnt1 !== 0 || rvalid0 !== 0 || rvalid1 !== 0 || rdata0 !== 0 || rdata1 !== 0 ||
        MemRead !== 0 || MemWrite !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      n_fail++;
      $display("FAIL reset_state gnt=%b%b rvalid=%b%b rdata0=%h rdata1=%h rd/wr=%b%b addr=%h wd=%h required all zero",
               gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, MemRead, MemWrite, mem_addr, mem_wdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single_read();
    do_reset();
    tbmem[4] = 32'hDEADBEEF;
    refmem[4] = 32'hDEADBEEF;
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    n_chk++;
    if (gnt0 !== 1 || gnt1 !== 0 || MemRead !== 1 || MemWrite !== 0 || mem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL single_read_issue gnt=%b%b rd/wr=%b%b addr=%h required 10 10 00000010",
               gnt0, gnt1, MemRead, MemWrite, mem_addr);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (rvalid0 !== 1 || rdata0 !== 32'hDEADBEEF || rvalid1 !== 0) begin
      n_fail++;
      $display("FAIL single_read_data rvalid0=%b rdata0=%h rvalid1=%b required 1 deadbeef 0", rvalid0, rdata0, rvalid1);
    end
    tick();
    n_chk++;
    if (rvalid0 !== 0 || rdata0 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rvalid_pulse rvalid0=%b rdata0=%h required 0 deadbeef", rvalid0, rdata0);
    end
  endtask

  task automatic test_contention();
    logic want1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 32'h20, 0, 1, 0, 32'h24, 0);
      want1 = ((i / 4) % 2) == 1;
      n_chk++;
      if (gnt1 !== want1 || gnt0 !== !want1) begin
        n_fail++;
        $display("FAIL contention cycle %0d gnt0=%b gnt1=%b required %b %b", i + 1, gnt0, gnt1, !want1, want1);
      end
      tick();
      if (i > 0) begin
        n_chk++;
        if (rvalid0 !== !want1 || rvalid1 !== want1) begin
          n_fail++;
          $display("FAIL contention_rvalid cycle %0d rvalid=%b%b required %b%b", i + 1, rvalid0, rvalid1, !want1, want1);
        end
      end
    end
  endtask

  task automatic test_write_then_read();
    do_reset();
    drive(0, 0, 0, 0, 1, 1, 32'h40, 32'h12345678);
    n_chk++;
    if (gnt1 !== 1 || MemWrite !== 1 || MemRead !== 0 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL write_issue gnt1=%b rd/wr=%b%b addr=%h wd=%h required 1 01 00000040 12345678",
               gnt1, MemRead, MemWrite, mem_addr, mem_wdata);
    end
    tick();
    n_chk++;
    if (rvalid1 !== 0) begin
      n_fail++;
      $display("FAIL write_no_rvalid rvalid1=%b required 0", rvalid1);
    end
    drive(1, 0, 32'h40, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (rvalid0 !== 1 || rdata0 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL write_readback rvalid0=%b rdata0=%h required 1 12345678", rvalid0, rdata0);
    end
    n_chk++;
    if (gnt0 !== 0 || gnt1 !== 0 || MemRead !== 0 || MemWrite !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      n_fail++;
      $display("FAIL idle_drive gnt=%b%b rd/wr=%b%b addr=%h wd=%h required all zero",
               gnt0, gnt1, MemRead, MemWrite, mem_addr, mem_wdata);
    end
    tick();
  endtask

  task automatic test_no_preempt();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'h30, 0, 0, 0, 0, 0);
      n_chk++;
      if (gnt0 !== 1) begin
        n_fail++;
        $display("FAIL no_preempt cycle %0d gnt0=%b required 1", i + 1, gnt0);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 32'h30, 0, 1, 0, 32'h34, 0);
      n_chk++;
      if (gnt1 !== 1 || gnt0 !== 0) begin
        n_fail++;
        $display("FAIL saturated_yield step %0d gnt0=%b gnt1=%b required 0 1", i, gnt0, gnt1);
      end
      tick();
    end
  endtask

  task automatic test_idle_gap();
    do_reset();
    drive(1, 0, 32'h8, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 32'h8, 0, 1, 0, 32'hC, 0);
    n_chk++;
    if (gnt1 !== 1 || gnt0 !== 0) begin
      n_fail++;
      $display("FAIL idle_gap_lrg gnt0=%b gnt1=%b required 0 1", gnt0, gnt1);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0, 32'h80 + 32'(4 * i), 0);
      tick();
      n_chk++;
      if (rvalid1 !== 1 || rdata1 !== refmem[32 + i]) begin
        n_fail++;
        $display("FAIL burst_read %0d rvalid1=%b rdata1=%h required 1 %h", i, rvalid1, rdata1, refmem[32 + i]);
      end
    end
    drive(0, 0, 0, 0, 1, 0, 32'h8C, 0);
    rst_n = 0;
    #1;
    n_chk++;
    if (rvalid1 !== 0 || rdata1 !== 0) begin
      n_fail++;
      $display("FAIL async_reset rvalid1=%b rdata1=%h required 0 00000000", rvalid1, rdata1);
    end
    tick();
    n_chk++;
    if (rvalid1 !== 0 || rdata1 !== 0) begin
      n_fail++;
      $display("FAIL reset_cycle_read rvalid1=%b rdata1=%h required 0 00000000", rvalid1, rdata1);
    end
    rst_n = 1;
    model_reset();
    drive(1, 0, 32'h90, 0, 1, 0, 32'h94, 0);
    n_chk++;
    if (gnt0 !== 1 || gnt1 !== 0) begin
      n_fail++;
      $display("FAIL post_reset_first gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
    end
    tick();
  endtask

  task automatic test_random();
    logic p_act [2];
    logic p_we [2];
    logic [31:0] p_a [2];
    logic [31:0] p_d [2];
    do_reset();
    p_act[0] = 0; p_act[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) if (!p_act[k]) begin
        p_act[k] = $urandom_range(0, 3) != 0;
        p_we[k] = $urandom_range(0, 1) == 1;
        p_a[k] = 32'($urandom_range(0, 63)) << 2;
        p_d[k] = $urandom;
      end
      drive(p_act[0], p_we[0], p_a[0], p_d[0], p_act[1], p_we[1], p_a[1], p_d[1]);
      n_chk++;
      if (gnt0 !== exp_g0 || gnt1 !== exp_g1 || MemRead !== exp_mr || MemWrite !== exp_mw ||
          mem_addr !== exp_addr || mem_wdata !== exp_wd) begin
        n_fail++;
        $display("FAIL random_issue cycle %0d gnt=%b%b rd/wr=%b%b addr=%h wd=%h required %b%b %b%b %h %h",
                 c, gnt0, gnt1, MemRead, MemWrite, mem_addr, mem_wdata,
                 exp_g0, exp_g1, exp_mr, exp_mw, exp_addr, exp_wd);
      end
      tick();
      n_chk++;
      if (rvalid0 !== exp_rv0 || rvalid1 !== exp_rv1 || rdata0 !== exp_rd0 || rdata1 !== exp_rd1) begin
        n_fail++;
        $display("FAIL random_read cycle %0d rvalid=%b%b rdata0=%h rdata1=%h required %b%b %h %h",
                 c, rvalid0, rvalid1, rdata0, rdata1, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
      end
      if (exp_w >= 0) p_act[exp_w] = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      tbmem[i] = 32'(i) * 32'h01010101 ^ 32'hA5000000;
      refmem[i] = 32'(i) * 32'h01010101 ^ 32'hA5000000;
    end
    test_reset();
    test_single_read();
    test_contention();
    test_write_then_read();
    test_no_preempt();
    test_idle_gap();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
